// File: rtl/mem_port_pkg.sv
// Shared types and default sizes for the mem_port_ctrl RAM port controller.
package mem_port_pkg;

  localparam int unsigned RamAwDef = 9;
  localparam int unsigned DwDef    = 32;
  localparam int unsigned BeWDef   = DwDef / 8;

  typedef enum logic [2:0] {
    StIdle,
    StRdIss,
    StRdCap,
    StWrIss,
    StRmwRd,
    StRmwCap,
    StRmwWr,
    StResp
  } state_e;

endpackage

// File: rtl/be_merge.sv
// Combinational byte merge: enabled bytes of new_word overlay old_word.
module be_merge #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0]   old_word,
  input  logic [DW-1:0]   new_word,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int b = 0; b < DW / 8; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-outstanding request/response controller in front of a 1-cycle-latency RAM.
// Optional address bounds checking is enabled by defining MEM_PORT_CTRL_BOUNDS_EN.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int unsigned RAM_AW = RamAwDef,
  parameter int unsigned DW     = DwDef
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic [DW/8-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wEn,
  output logic [DW-1:0]     ram_wDat,
  output logic              ram_rEn,
  input  logic [DW-1:0]     ram_rDat
);

  localparam int unsigned BW = DW / 8;

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] addr_q;
  logic [DW-1:0]     wdata_q;
  logic [BW-1:0]     be_q;
  logic [DW-1:0]     rdata_q;
  logic [DW-1:0]     merged_q;
  logic [DW-1:0]     merge_word;
  logic              accept;
  logic              bounds_err;

  // Byte-select bits never reach the RAM; upper bits only matter with bounds checking.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:RAM_AW+2], req_addr[1:0]};

  assign req_ready = (state_q == StIdle) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

`ifdef MEM_PORT_CTRL_BOUNDS_EN
  logic err_q;

  assign bounds_err = |req_addr[31:RAM_AW+2];
  assign rsp_err    = rsp_valid && err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= bounds_err;
    end
  end
`else
  assign bounds_err = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  be_merge #(
    .DW(DW)
  ) u_be_merge (
    .old_word(ram_rDat),
    .new_word(wdata_q),
    .be      (be_q),
    .merged  (merge_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bounds_err)                state_d = StResp;
          else if (!req_we)              state_d = StRdIss;
          else if (req_be == '0)         state_d = StResp;
          else if (req_be == {BW{1'b1}}) state_d = StWrIss;
          else                           state_d = StRmwRd;
        end
      end
      StRdIss:  state_d = StRdCap;
      StRdCap:  state_d = StResp;
      StWrIss:  state_d = StResp;
      StRmwRd:  state_d = StRmwCap;
      StRmwCap: state_d = StRmwWr;
      StRmwWr:  state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr[RAM_AW+1:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        rdata_q <= '0;
      end
      if (state_q == StRdCap)  rdata_q  <= ram_rDat;
      if (state_q == StRmwCap) merged_q <= merge_word;
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_wEn  = 1'b0;
    ram_rEn  = 1'b0;
    ram_wDat = '0;
    unique case (state_q)
      StRdIss, StRmwRd: begin
        ram_addr = addr_q;
        ram_rEn  = 1'b1;
      end
      StRdCap, StRmwCap: ram_addr = addr_q;
      StWrIss: begin
        ram_addr = addr_q;
        ram_wEn  = 1'b1;
        ram_wDat = wdata_q;
      end
      StRmwWr: begin
        ram_addr = addr_q;
        ram_wEn  = 1'b1;
        ram_wDat = merged_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed table, corner sequences, random vs. model.
module tb_mem_port_ctrl;

  localparam int unsigned RAM_AW = 9;
  localparam int unsigned DW     = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_wEn;
  logic [DW-1:0]     ram_wDat;
  logic              ram_rEn;
  logic [DW-1:0]     ram_rDat = '0;

  always #5 clock = ~clock;

  mem_port_ctrl #(
    .RAM_AW(RAM_AW),
    .DW    (DW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .ram_addr (ram_addr),
    .ram_wEn  (ram_wEn),
    .ram_wDat (ram_wDat),
    .ram_rEn  (ram_rEn),
    .ram_rDat (ram_rDat)
  );

  // RAM: registered read, updated only on a read; enables counted per cycle.
  logic [DW-1:0] mem [512];
  logic          ram_clr;
  int            ren_cnt  = 0;
  int            wen_cnt  = 0;
  int            both_cnt = 0;

  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
    end else begin
      if (ram_wEn) mem[ram_addr] <= ram_wDat;
      if (ram_rEn) ram_rDat <= mem[ram_addr];
    end
    if (ram_rEn) ren_cnt <= ren_cnt + 1;
    if (ram_wEn) wen_cnt <= wen_cnt + 1;
    if (ram_rEn && ram_wEn) both_cnt <= both_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: word memory plus the state-path length each request kind takes.
  logic [DW-1:0] ref_mem [512];

  task automatic ref_eval(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rd, output logic err,
                          output int lat, output int ren, output int wen);
    int unsigned w;
    w   = 32'(addr[10:2]);
    rd  = '0;
    err = 1'b0;
    lat = 0;
    ren = 0;
    wen = 0;
`ifdef MEM_PORT_CTRL_BOUNDS_EN
    if (addr[31:11] != 0) begin
      err = 1'b1;
      lat = 1;
      return;
    end
`endif
    if (!we) begin
      rd  = ref_mem[w];
      lat = 3;
      ren = 1;
    end else if (be == 4'h0) begin
      lat = 1;
    end else begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
      if (be == 4'hF) begin
        lat = 2;
        wen = 1;
      end else begin
        lat = 4;
        ren = 1;
        wen = 1;
      end
    end
  endtask

  // Caller is always at posedge+1. Returns response contents, edges from acceptance to
  // rsp_valid, and enable pulses seen.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, output logic [31:0] rd,
                        output logic err, output int lat, output int nren, output int nwen);
    int w;
    int ren0;
    int wen0;
    rd   = '0;
    err  = 1'b0;
    lat  = 0;
    nren = 0;
    nwen = 0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clock) #1;
      w++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    ren0 = ren_cnt;
    wen0 = wen_cnt;
    @(posedge clock) #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock) #1;
      lat++;
    end
    if (!rsp_valid) begin
      check("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
      return;
    end
    rd  = rsp_rdata;
    err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock) #1;
      check("backpressure_hold", {rsp_valid, rsp_err, req_ready, rsp_rdata},
            {1'b1, err, 1'b0, rd});
    end
    rsp_ready = 1'b1;
    @(posedge clock) #1;
    rsp_ready = 1'b0;
    check("post_handshake_idle", {rsp_valid, req_ready}, {1'b0, 1'b1});
    nren = ren_cnt - ren0;
    nwen = wen_cnt - wen0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ren;
    int          wen;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, erd;
    logic        err, eerr;
    int          lat, nren, nwen, elat, eren, ewen;
    int          wen_before;

    vecs.push_back('{1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0, 2, 0, 1});
    vecs.push_back('{1'b0, 32'h14, 32'h0,        4'hF, 4, 32'hDEADBEEF, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b1, 32'h1C, 32'h11223344, 4'hF, 1, 32'h0,        1'b0, 2, 0, 1});
    vecs.push_back('{1'b1, 32'h1C, 32'hAABBCCDD, 4'h5, 0, 32'h0,        1'b0, 4, 1, 1});
    vecs.push_back('{1'b0, 32'h1C, 32'h0,        4'h0, 2, 32'h11BB33DD, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b1, 32'h1F, 32'h99000000, 4'h8, 0, 32'h0,        1'b0, 4, 1, 1});
    vecs.push_back('{1'b0, 32'h1C, 32'h0,        4'h0, 0, 32'h99BB33DD, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b1, 32'h20, 32'h55667788, 4'h0, 0, 32'h0,        1'b0, 1, 0, 0});
    vecs.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 0, 32'h0,        1'b0, 3, 1, 0});
    vecs.push_back('{1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0, 2, 0, 1});
`ifdef MEM_PORT_CTRL_BOUNDS_EN
    vecs.push_back('{1'b1, 32'h800, 32'h12345678, 4'hF, 0, 32'h0, 1'b1, 1, 0, 0});
    vecs.push_back('{1'b0, 32'h800, 32'h0,        4'h0, 3, 32'h0, 1'b1, 1, 0, 0});
    vecs.push_back('{1'b0, 32'h0,   32'h0,        4'h0, 0, 32'h0, 1'b0, 3, 1, 0});
`else
    vecs.push_back('{1'b1, 32'h800, 32'h12345678, 4'hF, 0, 32'h0,        1'b0, 2, 0, 1});
    vecs.push_back('{1'b0, 32'h800, 32'h0,        4'h0, 3, 32'h12345678, 1'b0, 3, 1, 0});
    vecs.push_back('{1'b0, 32'h0,   32'h0,        4'h0, 0, 32'h12345678, 1'b0, 3, 1, 0});
`endif

    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    reset     = 1'b1;
    ram_clr   = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_ctrl", {req_ready, rsp_valid, rsp_err, ram_wEn, ram_rEn}, 64'd0);
    check("reset_data", {rsp_rdata, ram_wDat}, 64'd0);
    check("reset_addr", 64'(ram_addr), 64'd0);
    ram_clr = 1'b0;
    reset   = 1'b0;
    @(posedge clock) #1;
    check("ready_after_reset", {req_ready, rsp_valid}, {1'b1, 1'b0});

    foreach (vecs[i]) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold,
             rd, err, lat, nren, nwen);
      ref_eval(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, erd, eerr, elat, eren, ewen);
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].rdata));
      check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].err));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_ren_pulses", i), 64'(nren), 64'(vecs[i].ren));
      check($sformatf("vec%0d_wen_pulses", i), 64'(nwen), 64'(vecs[i].wen));
    end

    // Reset during the merge-capture cycle of a partial write to word 9.
    wen_before = wen_cnt;
    req_we    = 1'b1;
    req_addr  = 32'h24;
    req_wdata = 32'h00000000;
    req_be    = 4'h3;
    req_valid = 1'b1;
    check("abort_ready", 64'(req_ready), 64'd1);
    @(posedge clock) #1;
    req_valid = 1'b0;
    check("abort_rmw_rd", {ram_rEn, ram_wEn, 7'(ram_addr)}, {1'b1, 1'b0, 7'd9});
    @(posedge clock) #1;
    check("abort_rmw_cap", {ram_rEn, ram_wEn, 7'(ram_addr)}, {1'b0, 1'b0, 7'd9});
    reset = 1'b1;
    #1;
    check("abort_in_reset", {req_ready, rsp_valid, ram_wEn, ram_rEn, 9'(ram_addr)}, 64'd0);
    @(posedge clock) #1;
    reset = 1'b0;
    @(posedge clock) #1;
    check("abort_idle_after", {req_ready, rsp_valid}, {1'b1, 1'b0});
    check("abort_no_wen", 64'(wen_cnt - wen_before), 64'd0);
    do_txn(1'b0, 32'h24, 32'h0, 4'h0, 0, rd, err, lat, nren, nwen);
    check("abort_word_unchanged", 64'(rd), 64'hCAFEF00D);

    // Random traffic against the reference model.
    for (int t = 0; t < 150; t++) begin
      logic        we;
      logic [31:0] upper, word, addr, wdata;
      logic [3:0]  be;
      int          hold;
      we    = 1'($urandom_range(0, 1));
      word  = $urandom_range(0, 31);
      upper = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      addr  = {upper[20:0], word[8:0], 2'($urandom_range(0, 3))};
      wdata = $urandom;
      be    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      hold  = $urandom_range(0, 3);
      do_txn(we, addr, wdata, be, hold, rd, err, lat, nren, nwen);
      ref_eval(we, addr, wdata, be, erd, eerr, elat, eren, ewen);
      check($sformatf("rand%0d_rdata", t), 64'(rd), 64'(erd));
      check($sformatf("rand%0d_err", t), 64'(err), 64'(eerr));
      check($sformatf("rand%0d_latency", t), 64'(lat), 64'(elat));
      check($sformatf("rand%0d_enables", t), {32'(nren), 32'(nwen)}, {32'(eren), 32'(ewen)});
    end

    check("ren_wen_exclusive", 64'(both_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
